// File: rtl/data_memory.sv
// rtl/data_memory.sv - 256-bit line data memory with a fixed request-to-ack latency.
// Holds one request at a time. Storage is not reset, and its contents are never initialised.
module data_memory #(
   parameter int LATENCY = 10,
   parameter int DEPTH   = 512
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [31:0]  addr_i,
   input  logic [255:0] data_i,
   input  logic         enable_i,
   input  logic         write_i,
   output logic         ack_o,
   output logic [255:0] data_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [7:0] LAST = 8'(LATENCY - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] ACK  = 2'd2;

   logic [1:0]       state;
   logic [7:0]       cnt;
   logic [IDX_W-1:0] lat_idx;
   logic [255:0]     lat_data;
   logic             lat_write;
   logic             access;
   logic             unused_addr;

   logic [255:0] mem [0:DEPTH-1];

   // Only the line-index bits matter; all other address bits alias.
   assign unused_addr = ^addr_i;
   assign access      = (state == BUSY) && (cnt == LAST);

   always_ff @(posedge clk_i) begin
      if (state == IDLE && enable_i) begin
         lat_idx   <= addr_i[5 +: IDX_W];
         lat_data  <= data_i;
         lat_write <= write_i;
      end
   end

   // A reset forces the state to IDLE, so any write that is still in flight is dropped.
   always_ff @(posedge clk_i) begin
      if (access && lat_write)
         mem[lat_idx] <= lat_data;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state  <= IDLE;
         cnt    <= 8'd0;
         ack_o  <= 1'b0;
         data_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (enable_i) begin
                  cnt   <= 8'd0;
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (cnt == LAST) begin
                  state <= ACK;
                  ack_o <= 1'b1;
                  if (!lat_write)
                     data_o <= mem[lat_idx];
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ACK: begin
               ack_o <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               ack_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - directed self-checking bench for data_memory.
module tb_data_memory;

   logic         clk_i;
   logic         rst_i;
   logic [31:0]  addr_i;
   logic [255:0] data_i;
   logic         enable_i;
   logic         write_i;
   logic         ack_o;
   logic [255:0] data_o;

   logic [31:0]  addr1;
   logic [255:0] din1;
   logic         en1;
   logic         wr1;
   logic         ack1;
   logic [255:0] dout1;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   data_memory #(.LATENCY(10), .DEPTH(512)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .data_i(data_i),
      .enable_i(enable_i), .write_i(write_i), .ack_o(ack_o), .data_o(data_o)
   );

   data_memory #(.LATENCY(1), .DEPTH(512)) dut1 (
      .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr1), .data_i(din1),
      .enable_i(en1), .write_i(wr1), .ack_o(ack1), .data_o(dout1)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [255:0] pre(input int i);
      logic [31:0] w;
      w = 32'h1000_0000 + 32'(i);
      return {8{w}};
   endfunction

   // Waits for the next ack pulse; t is the cycle count at the sample, or -1 if none arrives.
   task automatic wait_ack(output int t);
      t = -1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk_i);
         if (ack_o) begin
            t = cyc;
            break;
         end
      end
   endtask

   // Issues one request; lat is the number of edges from acceptance to ack (-1 on timeout).
   task automatic run_req(input logic wr, input logic [31:0] a, input logic [255:0] d,
                          output int lat);
      @(negedge clk_i);
      enable_i = 1'b1; write_i = wr; addr_i = a; data_i = d;
      @(posedge clk_i);
      #1 enable_i = 1'b0;
      lat = -1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk_i);
         if (ack_o) begin
            lat = n;
            break;
         end
      end
   endtask

   int lat, t1, t2;
   logic saw_ack;

   initial begin
      rst_i = 1'b0; enable_i = 1'b0; write_i = 1'b0; addr_i = '0; data_i = '0;
      en1 = 1'b0; wr1 = 1'b0; addr1 = '0; din1 = '0;
      for (int i = 0; i < 8; i++) dut.mem[i] = pre(i);
      dut1.mem[5] = pre(5);
      repeat (3) @(negedge clk_i);
      check("reset_ack", {255'd0, ack_o}, 256'd0);
      check("reset_data", data_o, 256'd0);
      rst_i = 1'b1;

      // Write to line 31; data_o must not change.
      run_req(1'b1, 32'h0000_03E0, {8{32'hA5A5_0001}}, lat);
      check("wr_latency", 256'(lat), 256'd10);
      check("wr_data_o", data_o, 256'd0);
      @(negedge clk_i);
      check("wr_ack_pulse", {255'd0, ack_o}, 256'd0);
      check("wr_mem31", dut.mem[31], {8{32'hA5A5_0001}});

      // Read back line 31; data_o holds after ack drops.
      run_req(1'b0, 32'h0000_03E0, '0, lat);
      check("rd_latency", 256'(lat), 256'd10);
      check("rd_data", data_o, {8{32'hA5A5_0001}});
      @(negedge clk_i);
      check("rd_ack_drop", {255'd0, ack_o}, 256'd0);
      check("rd_data_held", data_o, {8{32'hA5A5_0001}});

      // Back-to-back reads with enable_i held high.
      @(negedge clk_i);
      enable_i = 1'b1; write_i = 1'b0; addr_i = 32'h0;
      @(posedge clk_i);
      #1 addr_i = 32'h20;
      wait_ack(t1);
      check("b2b_first_seen", {255'd0, t1 >= 0}, 256'd1);
      check("b2b_first_data", data_o, pre(0));
      wait_ack(t2);
      enable_i = 1'b0;
      check("b2b_spacing", 256'(t2 - t1), 256'd12);
      check("b2b_second_data", data_o, pre(1));
      @(negedge clk_i);

      // Inputs that change during BUSY must not affect the in-flight read.
      @(negedge clk_i);
      enable_i = 1'b1; write_i = 1'b0; addr_i = 32'h40; data_i = '0;
      @(posedge clk_i);
      #1 addr_i = 32'h60; write_i = 1'b1; data_i = {8{32'hDEAD_BEEF}};
      wait_ack(t1);
      enable_i = 1'b0;
      check("busy_ign_seen", {255'd0, t1 >= 0}, 256'd1);
      check("busy_ign_data", data_o, pre(2));
      @(negedge clk_i);
      check("busy_ign_mem3", dut.mem[3], pre(3));

      // Reset during BUSY abandons the write.
      @(negedge clk_i);
      enable_i = 1'b1; write_i = 1'b1; addr_i = 32'h80; data_i = {8{32'h5555_AAAA}};
      @(posedge clk_i);
      #1 enable_i = 1'b0;
      repeat (5) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      check("rst_busy_ack", {255'd0, ack_o}, 256'd0);
      check("rst_busy_data", data_o, 256'd0);
      saw_ack = 1'b0;
      repeat (3) begin
         @(negedge clk_i);
         if (ack_o) saw_ack = 1'b1;
      end
      rst_i = 1'b1;
      repeat (10) begin
         @(negedge clk_i);
         if (ack_o) saw_ack = 1'b1;
      end
      check("rst_no_ack", {255'd0, saw_ack}, 256'd0);
      check("rst_mem4", dut.mem[4], pre(4));
      run_req(1'b0, 32'h0000_4080, '0, lat);
      check("alias_latency", 256'(lat), 256'd10);
      check("alias_data", data_o, pre(4));
      @(negedge clk_i);

      // LATENCY=1 instance.
      @(negedge clk_i);
      en1 = 1'b1; wr1 = 1'b0; addr1 = 32'hA0;
      @(posedge clk_i);
      #1 en1 = 1'b0;
      @(negedge clk_i);
      check("lat1_not_yet", {255'd0, ack1}, 256'd0);
      @(negedge clk_i);
      check("lat1_ack", {255'd0, ack1}, 256'd1);
      check("lat1_data", dout1, pre(5));
      @(negedge clk_i);
      check("lat1_ack_drop", {255'd0, ack1}, 256'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
